// File: rtl/i2c_scl_gen.sv
// ============================================================================
// Module      : i2c_scl_gen
// Description : Master-side I2C SCL burst generator. It has a programmable
//               period and low phase, open-drain drive, and clock-stretch
//               detection. It emits fall, rise and sample strobes for the bit
//               FSM.
//               Optional stretch timeout is enabled by the I2C_SCL_TIMEOUT_EN
//               macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_scl_gen #(
    parameter int DIV_LEN     = 16,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DIV_LEN-1:0]     i_cfg_div,
    input  logic [DIV_LEN-1:0]     i_cfg_low,
    input  logic [CNT_W-1:0]       i_nbits,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_scl_in,
`ifdef I2C_SCL_TIMEOUT_EN
    input  logic [TIMEOUT_LEN-1:0] i_cfg_timeout,
    output logic                   o_timeout,
`endif
    output logic                   o_scl_oe,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_fall_stb,
    output logic                   o_rise_stb,
    output logic                   o_sample_stb,
    output logic                   o_stretch,
    output logic [DIV_LEN-1:0]     o_counter
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_WAIT = 2'd2,
        S_HIGH = 2'd3
    } state_t;

    localparam logic [DIV_LEN-1:0]     c_one      = DIV_LEN'(1);
    localparam logic [DIV_LEN-1:0]     c_two      = DIV_LEN'(2);
    localparam logic [CNT_W-1:0]       c_rem_one  = CNT_W'(1);
    localparam logic [TIMEOUT_LEN-1:0] c_wait_one = TIMEOUT_LEN'(1);
    localparam logic [TIMEOUT_LEN-1:0] c_wait_str = TIMEOUT_LEN'(2);

    state_t                 r_state;
    logic [DIV_LEN-1:0]     r_counter;
    logic [DIV_LEN-1:0]     r_div_q;
    logic [DIV_LEN-1:0]     r_low_q;
    logic [CNT_W-1:0]       r_rem;
    logic [TIMEOUT_LEN-1:0] r_wait_cnt;
    logic                   r_scl_meta;
    logic                   r_scl_oe;
    logic                   r_done;
    logic                   r_fall_stb;
    logic                   r_rise_stb;
    logic                   r_sample_stb;
    logic                   r_stretch;
`ifdef I2C_SCL_TIMEOUT_EN
    logic                   r_timeout;
`endif

    logic [DIV_LEN-1:0]     w_div_q;
    logic [DIV_LEN-1:0]     w_low_q;
    logic [DIV_LEN-1:0]     w_mid;
    logic [DIV_LEN-1:0]     w_cnt_inc;

    // Clamping keeps low_q in [1, div_q-1] so the phase counter never wraps.
    always_comb begin
        w_div_q = (i_cfg_div < c_two) ? c_two : i_cfg_div;
        if (i_cfg_low < c_one)
            w_low_q = c_one;
        else if (i_cfg_low > w_div_q - c_one)
            w_low_q = w_div_q - c_one;
        else
            w_low_q = i_cfg_low;
        w_mid     = r_low_q + ((r_div_q - r_low_q) >> 1);
        w_cnt_inc = r_counter + c_one;
    end

    // r_scl_meta is the first synchroniser stage. The WAIT-exit decision that
    // r_state registers is the second stage, so WAIT lasts two cycles with loopback.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_counter    <= '0;
            r_div_q      <= c_two;
            r_low_q      <= c_one;
            r_rem        <= '0;
            r_wait_cnt   <= '0;
            r_scl_meta   <= 1'b1;
            r_scl_oe     <= 1'b0;
            r_done       <= 1'b0;
            r_fall_stb   <= 1'b0;
            r_rise_stb   <= 1'b0;
            r_sample_stb <= 1'b0;
            r_stretch    <= 1'b0;
`ifdef I2C_SCL_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_scl_meta   <= i_scl_in;
            r_done       <= 1'b0;
            r_fall_stb   <= 1'b0;
            r_rise_stb   <= 1'b0;
            r_sample_stb <= 1'b0;
            r_stretch    <= 1'b0;
`ifdef I2C_SCL_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
            if (i_abort) begin
                r_state   <= S_IDLE;
                r_scl_oe  <= 1'b0;
                r_counter <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && (i_nbits != '0)) begin
                            r_div_q    <= w_div_q;
                            r_low_q    <= w_low_q;
                            r_rem      <= i_nbits;
                            r_counter  <= '0;
                            r_scl_oe   <= 1'b1;
                            r_fall_stb <= 1'b1;
                            r_state    <= S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (r_counter == r_low_q - c_one) begin
                            r_state    <= S_WAIT;
                            r_scl_oe   <= 1'b0;
                            r_wait_cnt <= c_wait_one;
                        end else begin
                            r_counter  <= w_cnt_inc;
                        end
                    end
                    S_WAIT: begin
                        if (r_scl_meta) begin
                            r_state      <= S_HIGH;
                            r_counter    <= r_low_q;
                            r_rise_stb   <= 1'b1;
                            r_sample_stb <= (r_low_q == w_mid);
`ifdef I2C_SCL_TIMEOUT_EN
                        end else if ((i_cfg_timeout != '0) && (r_wait_cnt == i_cfg_timeout)) begin
                            r_state   <= S_IDLE;
                            r_counter <= '0;
                            r_timeout <= 1'b1;
`endif
                        end else begin
                            if (r_wait_cnt != '1)
                                r_wait_cnt <= r_wait_cnt + c_wait_one;
                            r_stretch <= (r_wait_cnt >= c_wait_str);
                        end
                    end
                    S_HIGH: begin
                        if (r_counter == r_div_q - c_one) begin
                            r_rem <= r_rem - c_rem_one;
                            if (r_rem == c_rem_one) begin
                                r_state   <= S_IDLE;
                                r_counter <= '0;
                                r_done    <= 1'b1;
                            end else begin
                                r_state    <= S_LOW;
                                r_counter  <= '0;
                                r_scl_oe   <= 1'b1;
                                r_fall_stb <= 1'b1;
                            end
                        end else begin
                            r_counter    <= w_cnt_inc;
                            r_sample_stb <= (w_cnt_inc == w_mid);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_scl_oe     = r_scl_oe;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_fall_stb   = r_fall_stb;
    assign o_rise_stb   = r_rise_stb;
    assign o_sample_stb = r_sample_stb;
    assign o_stretch    = r_stretch;
    assign o_counter    = r_counter;
`ifdef I2C_SCL_TIMEOUT_EN
    assign o_timeout    = r_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_scl_gen.sv
// ============================================================================
// Module      : tb_i2c_scl_gen
// Description : Self-checking bench for i2c_scl_gen. The expected per-cycle
//               waveforms are built from the phase lengths of each SCL pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_scl_gen;

    logic        clk;
    logic        rstn;
    logic [15:0] cfg_div;
    logic [15:0] cfg_low;
    logic [3:0]  nbits;
    logic        start;
    logic        abort;
    logic        hold;
    logic        scl_in;
    logic        scl_oe;
    logic        busy;
    logic        done;
    logic        fall_stb;
    logic        rise_stb;
    logic        sample_stb;
    logic        stretch;
    logic [15:0] counter;
    logic        timeout;
`ifdef I2C_SCL_TIMEOUT_EN
    logic [15:0] cfg_timeout;
`else
    assign timeout = 1'b0;
`endif

    i2c_scl_gen #(.DIV_LEN(16), .CNT_W(4), .TIMEOUT_LEN(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_cfg_div    (cfg_div),
        .i_cfg_low    (cfg_low),
        .i_nbits      (nbits),
        .i_start      (start),
        .i_abort      (abort),
        .i_scl_in     (scl_in),
`ifdef I2C_SCL_TIMEOUT_EN
        .i_cfg_timeout(cfg_timeout),
        .o_timeout    (timeout),
`endif
        .o_scl_oe     (scl_oe),
        .o_busy       (busy),
        .o_done       (done),
        .o_fall_stb   (fall_stb),
        .o_rise_stb   (rise_stb),
        .o_sample_stb (sample_stb),
        .o_stretch    (stretch),
        .o_counter    (counter)
    );

    // The slave is modelled as an immediate loopback, optionally held low.
    assign scl_in = ~scl_oe & ~hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        oe;
        logic        busy;
        logic        done;
        logic        fall;
        logic        rise;
        logic        sample;
        logic        stretch;
        logic        tmo;
        logic        cnt_v;
        logic [15:0] cnt;
        logic        hold;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Each pulse is low_q cycles low, 2+extra cycles waiting for SCL, then div_q-low_q high.
    task automatic gen_burst(input int div, input int low, input int n, input int sp, input int h);
        int   dq;
        int   lq;
        exp_t e;
        dq = (div < 2) ? 2 : div;
        lq = (low < 1) ? 1 : ((low > dq - 1) ? dq - 1 : low);
        for (int p = 0; p < n; p++) begin
            for (int j = 0; j < lq; j++) begin
                e = '0; e.oe = 1'b1; e.busy = 1'b1; e.fall = (j == 0);
                e.cnt_v = 1'b1; e.cnt = 16'(j);
                q.push_back(e);
            end
            for (int j = 0; j < 2 + ((p == sp) ? h : 0); j++) begin
                e = '0; e.busy = 1'b1; e.stretch = (j >= 2);
                e.hold = (p == sp) && (j < h);
                e.cnt_v = 1'b1; e.cnt = 16'(lq - 1);
                q.push_back(e);
            end
            for (int j = 0; j < dq - lq; j++) begin
                e = '0; e.busy = 1'b1; e.rise = (j == 0); e.sample = (j == (dq - lq) / 2);
                e.cnt_v = 1'b1; e.cnt = 16'(lq + j);
                q.push_back(e);
            end
        end
        e = '0; e.done = 1'b1;
        q.push_back(e);
        e = '0;
        repeat (3) q.push_back(e);
    endtask

    task automatic gen_idle(input int n);
        exp_t e;
        e = '0;
        repeat (n) q.push_back(e);
    endtask

    task automatic kick(input int div, input int low, input int n, input bit ab);
        @(negedge clk);
        cfg_div = 16'(div);
        cfg_low = 16'(low);
        nbits   = 4'(n);
        start   = 1'b1;
        abort   = ab;
    endtask

    // Walks the expected trace. From cycle cut onward, abort or reset is applied and idle is expected.
    task automatic run_trace(input string name, input bit noise, input int cut, input bit is_rst);
        int         len;
        exp_t       e;
        logic [7:0] act;
        logic [7:0] expv;
        len = (cut >= 0) ? cut + 4 : q.size();
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (cut >= 0 && c > cut) begin
                e = '0; e.cnt_v = is_rst;
            end else begin
                e = q[c];
            end
            act  = {scl_oe, busy, done, fall_stb, rise_stb, sample_stb, stretch, timeout};
            expv = {e.oe, e.busy, e.done, e.fall, e.rise, e.sample, e.stretch, e.tmo};
            n_cmp++;
            if (act !== expv || (e.cnt_v && counter !== e.cnt)) begin
                n_err++;
                $display("FAIL %s cycle %0d: oe,busy,done,fall,rise,sample,stretch,tmo got=%b exp=%b counter got=%0d exp=%0d",
                         name, c, act, expv, counter, e.cnt_v ? e.cnt : counter);
            end
            hold  = e.hold;
            start = 1'b0;
            abort = 1'b0;
            rstn  = 1'b1;
            if (noise && e.busy && $urandom_range(0, 2) == 0) begin
                start   = 1'b1;
                nbits   = 4'($urandom_range(0, 15));
                cfg_div = 16'($urandom_range(1, 30));
                cfg_low = 16'($urandom_range(0, 30));
            end
            if (c == cut) begin
                if (is_rst) rstn = 1'b0;
                else abort = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rstn  = 1'b1;
        hold  = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({scl_oe, busy, done, fall_stb, rise_stb, sample_stb, stretch, timeout} !== 8'b0 || counter !== 16'd0) begin
            n_err++;
            $display("FAIL reset: flags got=%b exp=00000000 counter got=%0d exp=0",
                     {scl_oe, busy, done, fall_stb, rise_stb, sample_stb, stretch, timeout}, counter);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        gen_burst(10, 5, 3, -1, 0);
        kick(10, 5, 3, 1'b0);
        run_trace("basic", 1'b0, -1, 1'b0);
    endtask

    task automatic test_stretch();
        gen_burst(10, 5, 3, 1, 20);
        kick(10, 5, 3, 1'b0);
        run_trace("stretch", 1'b0, -1, 1'b0);
    endtask

    task automatic test_clamp();
        gen_burst(1, 0, 1, -1, 0);
        kick(1, 0, 1, 1'b0);
        run_trace("clamp", 1'b0, -1, 1'b0);
        gen_burst(6, 9, 2, -1, 0);
        kick(6, 9, 2, 1'b0);
        run_trace("clamp_low_max", 1'b0, -1, 1'b0);
    endtask

    task automatic test_abort();
        gen_burst(10, 5, 3, -1, 0);
        kick(10, 5, 3, 1'b0);
        run_trace("abort", 1'b0, 14, 1'b0);
        gen_burst(4, 2, 2, -1, 0);
        kick(4, 2, 2, 1'b0);
        run_trace("after_abort", 1'b0, -1, 1'b0);
    endtask

    task automatic test_ignored_start();
        gen_burst(10, 5, 3, -1, 0);
        kick(10, 5, 3, 1'b0);
        run_trace("start_while_busy", 1'b1, -1, 1'b0);
        gen_idle(6);
        kick(10, 5, 0, 1'b0);
        run_trace("nbits_zero", 1'b0, -1, 1'b0);
        gen_idle(6);
        kick(10, 5, 3, 1'b1);
        run_trace("start_and_abort_idle", 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        int div;
        int low;
        int n;
        for (int k = 0; k < 8; k++) begin
            div = $urandom_range(1, 14);
            low = $urandom_range(0, 16);
            n   = $urandom_range(1, 4);
            gen_burst(div, low, n, $urandom_range(0, n - 1), $urandom_range(0, 6));
            kick(div, low, n, 1'b0);
            run_trace("random", 1'b1, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        gen_burst(8, 3, 3, -1, 0);
        kick(8, 3, 3, 1'b0);
        run_trace("reset_mid_burst", 1'b0, 12, 1'b1);
    endtask

`ifdef I2C_SCL_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        for (int j = 0; j < 5; j++) begin
            e = '0; e.oe = 1'b1; e.busy = 1'b1; e.fall = (j == 0);
            e.cnt_v = 1'b1; e.cnt = 16'(j);
            q.push_back(e);
        end
        for (int j = 0; j < 8; j++) begin
            e = '0; e.busy = 1'b1; e.stretch = (j >= 2); e.hold = 1'b1;
            e.cnt_v = 1'b1; e.cnt = 16'd4;
            q.push_back(e);
        end
        e = '0; e.tmo = 1'b1;
        q.push_back(e);
        gen_idle(3);
        cfg_timeout = 16'd8;
        kick(10, 5, 2, 1'b0);
        run_trace("timeout", 1'b0, -1, 1'b0);
        cfg_timeout = 16'd0;
    endtask
`endif

    initial begin
        rstn    = 1'b0;
        cfg_div = 16'd10;
        cfg_low = 16'd5;
        nbits   = 4'd0;
        start   = 1'b0;
        abort   = 1'b0;
        hold    = 1'b0;
`ifdef I2C_SCL_TIMEOUT_EN
        cfg_timeout = 16'd0;
`endif
        test_reset();
        test_basic();
        test_stretch();
        test_clamp();
        test_abort();
        test_ignored_start();
        test_random();
        test_reset_mid_burst();
`ifdef I2C_SCL_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
